// File: rtl/display_pkg.sv
// Display scheduler shared types: mode encoding and decoder digit codes.
package display_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_LEFT  = 2'd1,
    MODE_RIGHT = 2'd2,
    MODE_STOP  = 2'd3
  } mode_e;

  localparam logic [3:0] DIG_RIGHT = 4'd10;
  localparam logic [3:0] DIG_LEFT  = 4'd11;
  localparam logic [3:0] DIG_BLANK = 4'd12;
  localparam logic [3:0] DIG_ALL   = 4'd8;

  typedef struct packed {
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic [3:0] d4;
  } digits_t;

endpackage

// File: rtl/bcd_counter_2d.sv
// Two-digit BCD lap counter fed by an asynchronous event input.
module bcd_counter_2d (
  input  logic       clock,
  input  logic       reset,
  input  logic       inc,
  input  logic       clear,
  output logic [3:0] tens,
  output logic [3:0] units
);

  // sync[1:0] resynchronise inc; sync[2] is kept for edge detection
  logic [2:0] sync;
  logic       bump;

  assign bump = sync[1] & ~sync[2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync  <= '0;
      tens  <= '0;
      units <= '0;
    end else begin
      sync <= {sync[1:0], inc};
      if (clear) begin
        tens  <= '0;
        units <= '0;
      end else if (bump) begin
        if (units == 4'd9) begin
          units <= '0;
          tens  <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
          units <= units + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Turn/stop/lap display scheduler driving four decoder digit codes.
module display_scheduler
  import display_pkg::*;
#(
  parameter int BLINK_DIV   = 25000000,
  parameter int HOLD_BLINKS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       semnal_stanga,
  input  logic       semnal_dreapta,
  input  logic       stop,
  input  logic       tact_count,
  input  logic       count_clear,
  output logic [3:0] digit_1,
  output logic [3:0] digit_2,
  output logic [3:0] digit_3,
  output logic [3:0] digit_4,
  output logic [1:0] mode
);

  localparam int DW = $clog2(BLINK_DIV + 1);
  localparam int HW = $clog2(HOLD_BLINKS + 2);
  localparam logic [DW-1:0] DIV_LAST  = DW'(BLINK_DIV - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_BLINKS);

  mode_e         state;
  mode_e         nxt;
  logic [DW-1:0] div;
  logic [HW-1:0] hold;
  logic          phase;
  logic          tick;
  logic          own_req;
  logic          turn_entry;
  logic [3:0]    tens;
  logic [3:0]    units;
  digits_t       dig;
  digits_t       dig_nxt;

  bcd_counter_2d u_lap (
    .clock (clock),
    .reset (reset),
    .inc   (tact_count),
    .clear (count_clear),
    .tens  (tens),
    .units (units)
  );

  assign tick    = (div == DIV_LAST);
  assign own_req = (state == MODE_LEFT) ? semnal_stanga
                                        : semnal_dreapta;

  always_comb begin
    nxt = state;
    priority case (1'b1)
      stop:           nxt = MODE_STOP;
      semnal_stanga:  nxt = MODE_LEFT;
      semnal_dreapta: nxt = MODE_RIGHT;
      default: begin
        if (state == MODE_STOP || hold == '0)
          nxt = MODE_COUNT;
      end
    endcase
  end

  assign turn_entry = (nxt != state) &&
                      (nxt == MODE_LEFT || nxt == MODE_RIGHT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= MODE_COUNT;
      div   <= '0;
      hold  <= '0;
      phase <= 1'b1;
    end else begin
      state <= nxt;
      if (turn_entry) begin
        div   <= '0;
        phase <= 1'b1;
        hold  <= HOLD_INIT;
      end else begin
        div <= tick ? '0 : div + DW'(1);
        if (tick)
          phase <= ~phase;
        if (nxt == MODE_COUNT || nxt == MODE_STOP)
          hold <= '0;
        else if (own_req)
          hold <= HOLD_INIT;
        else if (tick && hold != '0)
          hold <= hold - HW'(1);
      end
    end
  end

  always_comb begin
    dig_nxt = '{DIG_BLANK, DIG_BLANK, DIG_BLANK, DIG_BLANK};
    unique case (state)
      MODE_COUNT: dig_nxt = '{DIG_BLANK, tens, units, DIG_BLANK};
      MODE_STOP:  dig_nxt = '{DIG_ALL, DIG_ALL, DIG_ALL, DIG_ALL};
      MODE_LEFT:  if (phase) dig_nxt.d1 = DIG_LEFT;
      MODE_RIGHT: if (phase) dig_nxt.d4 = DIG_RIGHT;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      dig <= '{DIG_BLANK, 4'd0, 4'd0, DIG_BLANK};
    else
      dig <= dig_nxt;
  end

  assign digit_1 = dig.d1;
  assign digit_2 = dig.d2;
  assign digit_3 = dig.d3;
  assign digit_4 = dig.d4;
  assign mode    = state;

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 The block SHALL have parameter BLINK_DIV, default 25000000, meaning clock cycles per blink tick (0.5 s at 50 MHz).
REQ-002 The block SHALL have parameter HOLD_BLINKS, default 2, meaning blink ticks a turn indication is held after its request drops.
REQ-003 The block SHALL have port clock, input, 1, the single system clock, with all state on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, the asynchronous active-high reset.
REQ-005 The block SHALL have port semnal_stanga, input, 1, the left-turn request level.
REQ-006 The block SHALL have port semnal_dreapta, input, 1, the right-turn request level.
REQ-007 The block SHALL have port stop, input, 1, the stop request level.
REQ-008 The block SHALL have port tact_count, input, 1, the asynchronous lap event.
REQ-009 The block SHALL have port count_clear, input, 1, a synchronous clear of the lap counter.
REQ-010 The block SHALL have ports digit_1, digit_2, digit_3 and digit_4, each output, 4 bits, the registered decoder codes for positions D1 to D4.
REQ-011 The block SHALL have port mode, output, 2 bits, the current state: 0 COUNT, 1 LEFT, 2 RIGHT, 3 STOP.

Function
REQ-012 Digit codes SHALL be: 0-9 for digits, 10 for right arrow, 11 for left arrow, 12 for blank, and 8 for all segments on.
REQ-013 tact_count SHALL pass through a 2-flop synchronizer; each synchronized rising edge SHALL increment the 2-digit BCD lap counter by one.
REQ-014 The lap counter SHALL count 00..99 and wrap 99->00; units wrap 9->0 SHALL carry into tens in the same cycle.
REQ-015 count_clear SHALL set the counter to 00 and SHALL win over a simultaneous increment.
REQ-016 The lap counter SHALL keep counting in every state.
REQ-017 The FSM SHALL have states COUNT, LEFT, RIGHT and STOP, with request priority stop > semnal_stanga > semnal_dreapta.
REQ-018 From any state, stop=1 SHALL enter STOP on the next edge.
REQ-019 STOP SHALL exit on the edge after stop=0, with no hold, to the highest active turn request, or to COUNT if none is active.
REQ-020 In COUNT or RIGHT, semnal_stanga=1 (stop=0) SHALL enter LEFT on the next edge.
REQ-021 In COUNT, semnal_dreapta=1 alone SHALL enter RIGHT on the next edge.
REQ-022 In LEFT, semnal_dreapta=1 with semnal_stanga=0 SHALL enter RIGHT immediately, without waiting for the hold.
REQ-023 A hold counter SHALL reload to HOLD_BLINKS on every cycle the state's own request is active.
REQ-024 The hold counter SHALL decrement on each blink tick while the request is inactive.
REQ-025 LEFT/RIGHT SHALL return to COUNT when the request is inactive and the hold counter is 0.
REQ-026 When semnal_stanga and semnal_dreapta are both 1, LEFT SHALL be selected.
REQ-027 The blink divider SHALL pulse blink_tick for one cycle every BLINK_DIV cycles; each pulse SHALL toggle blink_phase.
REQ-028 Entry into LEFT or RIGHT SHALL restart the divider and set blink_phase=1.
REQ-029 In COUNT the digits SHALL be 12, tens, units, 12.
REQ-030 In STOP the digits SHALL be 8, 8, 8, 8, steady.
REQ-031 In LEFT the digits SHALL be 11, 12, 12, 12 when blink_phase=1, and all 12 when blink_phase=0.
REQ-032 In RIGHT the digits SHALL be 12, 12, 12, 10 when blink_phase=1, and all 12 when blink_phase=0.
REQ-033 The digit outputs SHALL be registered, with 1-cycle latency from a state or counter change.

Reset
REQ-034 Reset SHALL force state=COUNT, counter=00, hold=0, divider=0, blink_phase=1 and synchronizer flops=0.
REQ-035 Reset SHALL force the outputs to digits 12,0,0,12 and mode=0.
REQ-036 Reset SHALL take effect immediately, mid-blink or mid-hold; after release, the first transition SHALL follow the request inputs.

Structure
REQ-037 Package display_pkg SHALL hold the digit-code constants (DIG_BLANK=12, DIG_LEFT=11, DIG_RIGHT=10, DIG_ALL=8) and the mode/state encoding.
REQ-038 The lap counter and its synchronizer SHALL be the single sub-module bcd_counter_2d, with ports clock, reset, inc, clear, tens and units.

Verification
REQ-039 The bench SHALL run BLINK_DIV=4 and HOLD_BLINKS=2 and cover each of the scenarios REQ-040 to REQ-044.
REQ-040 99 tact_count pulses then 1 more -> units/tens read 9/9, then 0/0; digits show 12,0,0,12.
REQ-041 semnal_stanga pulse of 1 cycle -> LEFT; digits alternate 11,12,12,12 / all 12 every 4 cycles; COUNT resumes 8 cycles after the drop (2 blink ticks) plus 1.
REQ-042 In LEFT, raise stop -> STOP and 8,8,8,8 after 2 edges; drop stop with semnal_dreapta=1 -> RIGHT, digit_4=10.
REQ-043 Both semnal_stanga and semnal_dreapta high from COUNT -> mode=1; tact_count pulses during LEFT -> counter still advances and is shown on return to COUNT.
REQ-044 Assert reset mid-hold in RIGHT with counter 37 -> outputs 12,0,0,12 and mode=0 immediately; count_clear together with a tact edge -> counter 00.
